mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the ARM pipeline, between the EXE stage register and the WB stage register. ALU-only instructions pass through in one cycle. LDR/STR instructions run a request/acknowledge transaction on a word-wide data-memory bus, and the stage freezes upstream stages until the transaction completes. Results are registered toward WB: write-back enable, ALU result, loaded data, destination register and PC.

## Interface
- `MEM_BASE`, default 1024: byte address mapped to data-memory word 0.
- `MEM_WORDS`, default 64: size of data memory in words.
- `TIMEOUT`, default 15: maximum wait cycles for `mem_ack` before the access is aborted.

- `clk`  in  1  clock. All state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous. Kill the instruction currently held in this stage.
- `valid_in`  in  1  EXE register holds a live instruction.
- `pc_in`  in  32  instruction PC.
- `alu_res_in`  in  32  ALU result; byte address for LDR/STR.
- `st_val_in`  in  32  store data.
- `dest_in`  in  4  destination register.
- `wb_en_in`  in  1  write-back enable.
- `mem_r_en_in`  in  1  load.
- `mem_w_en_in`  in  1  store.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word index: (`alu_res` − `MEM_BASE`) >> 2.
- `mem_wdata`  out  32  store data.
- `mem_ack`  in  1  transaction complete. Read data is valid in the same cycle.
- `mem_rdata`  in  32  read data.
- `freeze_out`  out  1  stall upstream stages. Combinational.
- `valid_out`, `wb_en_out`, `mem_r_en_out`  out  1 each  registered toward WB.
- `pc_out`, `alu_res_out`, `mem_data_out`  out  32 each  registered toward WB.
- `dest_out`  out  4  registered toward WB.
- `err`  out  1  one-cycle registered pulse on a bad address or a timeout.

## Operation
- **Memory op.** `mem_op` = `valid_in` & (`mem_r_en_in` | `mem_w_en_in`). If both enables are set, the instruction is treated as a store.
- **Address check.** An address is bad if `alu_res_in[1:0]` ≠ 0, or if it lies outside [`MEM_BASE`, `MEM_BASE` + 4·`MEM_WORDS`).
- **FSM states:** IDLE, ACCESS.
  - IDLE, `mem_op` with a good address, no `flush` → ACCESS. Latch the address index, `st_val`, the write flag and the instruction fields. Clear the wait counter.
  - IDLE, `mem_op` with a bad address → stay in IDLE. No request is issued. Pulse `err`. Load a bubble.
  - IDLE, non-memory instruction → load `valid_in`, `wb_en_in`, `alu_res_in`, `dest_in` and `pc_in` into the output registers. `mem_data_out` holds its previous value.
  - ACCESS: `mem_req` = 1. `mem_we`, `mem_addr` and `mem_wdata` come from the latched copies.
    - On `mem_ack` → IDLE. Load the output registers from the latch; `mem_data_out` ← `mem_rdata` for loads.
    - With no ack, the counter increments. When the counter equals `TIMEOUT` → IDLE, pulse `err`, load a bubble.
- **Freeze.** `freeze_out` = (IDLE & `mem_op` & good address & ~`flush`) | (ACCESS & ~`mem_ack` & ~timeout). Upstream stages hold their inputs stable while it is high.
- **Bubble loading.** While `freeze_out` = 1, the output registers load a bubble: `valid_out` = 0 and `wb_en_out` = 0. WB never sees a duplicated instruction.
- **Flush in IDLE.** A bubble is loaded and no request is issued.
- **Flush in ACCESS.** The bus transaction still completes (a write is committed). The captured result is loaded as a bubble.
- **Outputs on `mem_ack`.**
  - Load: `wb_en_out` = latched `wb_en`, `mem_r_en_out` = 1.
  - Store: `wb_en_out` = 0.
- **Reset.** Every output register resets to 0 and the FSM to IDLE. `mem_req` drops asynchronously, including in the middle of an ACCESS.

## Timing
- Non-memory instruction: 1-cycle latency.
- Memory instruction:
  - Cycle 0: the instruction is presented and `freeze_out` = 1.
  - Cycle 1 onward: `mem_req` = 1.
  - Ack in cycle k: the result is visible after edge k+1, and `freeze_out` = 0 in cycle k.
  - Minimum latency is 2 cycles, with ack in cycle 1.
- Timeout: `mem_req` stays high for `TIMEOUT` + 1 cycles, then drops. `err` is high in the following cycle.
- `mem_ack` while not in ACCESS: ignored.

## Structure
- Package `arm_mem_pkg`:
  - state enum {IDLE, ACCESS};
  - default values for `MEM_BASE` and `MEM_WORDS`;
  - a packed struct for the instruction fields (pc, alu_res, st_val, dest, wb_en, mem_r_en, mem_w_en).
- Sub-module `mem_bus_fsm`: the state register, latch, wait counter, bus outputs and `freeze_out`.
- Top level: the address check and the output register bank.

## Test plan
- ADD with `alu_res_in` = 0x0000_0005 and `dest_in` = 3 → after 1 edge: `valid_out` = 1, `wb_en_out` = 1, `alu_res_out` = 5, `dest_out` = 3. `freeze_out` stays 0.
- STR to 1028 with `st_val_in` = 0xDEAD_BEEF, ack in cycle 3 → `mem_addr` = 1, `mem_we` = 1, `freeze_out` high in cycles 0–2. Output after edge 4: `valid_out` = 1, `wb_en_out` = 0.
- LDR to 1032, ack in cycle 1 with `mem_rdata` = 0x1234 → after edge 2: `mem_data_out` = 0x1234, `mem_r_en_out` = 1, `wb_en_out` = 1.
- LDR to 1026 (misaligned), and separately to 900 (below base) → `mem_req` never asserts, `err` pulses once, bubble is output.
- LDR with no ack and `TIMEOUT` = 15 → `mem_req` high for 16 cycles, then `err` = 1 for one cycle, bubble is output, `freeze_out` = 0.
- Reset mid-ACCESS (`rst` = 0 in cycle 2) → `mem_req` = 0 immediately, all outputs 0. A memory op presented after reset is released starts a fresh transaction.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared types and defaults for the memory-access pipeline stage.
// Holds the FSM state encoding and the instruction bundle carried through a bus access.
package arm_mem_pkg;

    localparam int MEM_BASE_DEF  = 1024;
    localparam int MEM_WORDS_DEF = 64;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_res;
        logic [31:0] st_val;
        logic [3:0]  dest;
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
    } instr_t;

endpackage

// File: rtl/mem_stage_if.sv
// Word-wide data-memory request/acknowledge bus: the stage is master, the memory is slave.
// Read data is qualified by mem_ack in the same cycle.
interface mem_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_bus_fsm.sv
// Bus sequencer: latches a memory op, holds mem_req until ack or timeout, drives freeze.
// One cycle to enter ACCESS, then completes in the ack cycle; upstream frozen throughout.
module mem_bus_fsm
  import arm_mem_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               start,
  input  logic [31:0]        idx_in,
  input  instr_t             instr_in,
  mem_stage_if.master        bus,
  output logic               busy,
  output logic               freeze,
  output logic               done,
  output logic               timeout,
  output logic               done_vld,
  output logic               done_load,
  output logic               done_wb_en,
  output logic [31:0]        done_pc,
  output logic [31:0]        done_alu_res,
  output logic [3:0]         done_dest
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [0:0] S_IDLE   = ST_IDLE;
  localparam logic [0:0] S_ACCESS = ST_ACCESS;

  logic [0:0]    state_q, state_d;
  instr_t        lat_q, lat_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          kill_q, kill_d;

  assign busy    = (state_q == S_ACCESS);
  assign done    = busy & bus.mem_ack;
  assign timeout = busy & ~bus.mem_ack & (cnt_q == CW'(TIMEOUT));
  assign freeze  = (~busy & start) | (busy & ~bus.mem_ack & ~timeout);

  assign bus.mem_req   = busy;
  assign bus.mem_we    = lat_q.mem_w_en;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = lat_q.st_val;

  // A flush during the access still lets the bus finish; only the result is killed.
  assign done_vld     = ~(kill_q | flush);
  assign done_load    = lat_q.mem_r_en & ~lat_q.mem_w_en;
  assign done_wb_en   = lat_q.wb_en & done_load;
  assign done_pc      = lat_q.pc;
  assign done_alu_res = lat_q.alu_res;
  assign done_dest    = lat_q.dest;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    kill_d  = kill_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCESS;
          lat_d   = instr_in;
          addr_d  = idx_in;
          cnt_d   = '0;
          kill_d  = 1'b0;
        end
      end
      default: begin
        if (flush) kill_d = 1'b1;
        if (done || timeout) state_d = S_IDLE;
        else                 cnt_d   = cnt_q + CW'(1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// ARM MEM stage: address check plus WB-facing register bank; ALU ops take 1 cycle, LDR/STR >= 2.
// Freezes upstream combinationally while a bus access is pending; bubbles are loaded meanwhile.
module mem_stage
  import arm_mem_pkg::*;
#(
  parameter int MEM_BASE  = MEM_BASE_DEF,
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] st_val_in,
  input  logic [3:0]  dest_in,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  mem_stage_if.master mem_bus,
  output logic        freeze_out,
  output logic        valid_out,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic [31:0] pc_out,
  output logic [31:0] alu_res_out,
  output logic [31:0] mem_data_out,
  output logic [3:0]  dest_out,
  output logic        err
);

  localparam logic [32:0] ADDR_LO = 33'(MEM_BASE);
  localparam logic [32:0] ADDR_HI = 33'(MEM_BASE) + 33'(4 * MEM_WORDS);

  logic        mem_op, addr_ok, start;
  logic [31:0] idx;
  instr_t      instr;

  logic        busy, done, timeout, done_vld, done_load, done_wb_en;
  logic [31:0] done_pc, done_alu_res;
  logic [3:0]  done_dest;

  assign mem_op  = valid_in & (mem_r_en_in | mem_w_en_in);
  assign addr_ok = (alu_res_in[1:0] == 2'b00) &&
                   ({1'b0, alu_res_in} >= ADDR_LO) &&
                   ({1'b0, alu_res_in} <  ADDR_HI);
  assign start   = mem_op & addr_ok & ~flush;
  assign idx     = (alu_res_in - 32'(MEM_BASE)) >> 2;
  assign instr   = '{pc: pc_in, alu_res: alu_res_in, st_val: st_val_in, dest: dest_in,
                     wb_en: wb_en_in, mem_r_en: mem_r_en_in, mem_w_en: mem_w_en_in};

  mem_bus_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .start        (start),
    .idx_in       (idx),
    .instr_in     (instr),
    .bus          (mem_bus),
    .busy         (busy),
    .freeze       (freeze_out),
    .done         (done),
    .timeout      (timeout),
    .done_vld     (done_vld),
    .done_load    (done_load),
    .done_wb_en   (done_wb_en),
    .done_pc      (done_pc),
    .done_alu_res (done_alu_res),
    .done_dest    (done_dest)
  );

  logic        valid_q, valid_d, wb_en_q, wb_en_d, mem_r_en_q, mem_r_en_d, err_q, err_d;
  logic [31:0] pc_q, pc_d, alu_res_q, alu_res_d, mem_data_q, mem_data_d;
  logic [3:0]  dest_q, dest_d;

  always_comb begin
    valid_d    = valid_q;
    wb_en_d    = wb_en_q;
    mem_r_en_d = mem_r_en_q;
    pc_d       = pc_q;
    alu_res_d  = alu_res_q;
    mem_data_d = mem_data_q;
    dest_d     = dest_q;
    err_d      = 1'b0;
    if (done) begin
      valid_d    = done_vld;
      wb_en_d    = done_vld & done_wb_en;
      mem_r_en_d = done_vld & done_load;
      pc_d       = done_pc;
      alu_res_d  = done_alu_res;
      dest_d     = done_dest;
      if (done_load) mem_data_d = mem_bus.mem_rdata;
    end else if (timeout || busy || freeze_out || flush || mem_op) begin
      // Everything left here is a bubble; only timeouts and bad addresses flag an error.
      valid_d    = 1'b0;
      wb_en_d    = 1'b0;
      mem_r_en_d = 1'b0;
      err_d      = timeout | (~busy & ~flush & mem_op & ~addr_ok);
    end else begin
      valid_d    = valid_in;
      wb_en_d    = wb_en_in;
      mem_r_en_d = 1'b0;
      pc_d       = pc_in;
      alu_res_d  = alu_res_in;
      dest_d     = dest_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      pc_q       <= '0;
      alu_res_q  <= '0;
      mem_data_q <= '0;
      dest_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      wb_en_q    <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      pc_q       <= pc_d;
      alu_res_q  <= alu_res_d;
      mem_data_q <= mem_data_d;
      dest_q     <= dest_d;
      err_q      <= err_d;
    end
  end

  assign valid_out    = valid_q;
  assign wb_en_out    = wb_en_q;
  assign mem_r_en_out = mem_r_en_q;
  assign pc_out       = pc_q;
  assign alu_res_out  = alu_res_q;
  assign mem_data_out = mem_data_q;
  assign dest_out     = dest_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, load/store handshakes, bad addresses, timeout, flush, reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        valid_in;
  logic [31:0] pc_in, alu_res_in, st_val_in;
  logic [3:0]  dest_in;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic        freeze_out, valid_out, wb_en_out, mem_r_en_out, err;
  logic [31:0] pc_out, alu_res_out, mem_data_out;
  logic [3:0]  dest_out;

  int n_tests = 0;
  int n_fail  = 0;
  int req_cnt;

  mem_stage_if bus();

  mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .valid_in     (valid_in),
    .pc_in        (pc_in),
    .alu_res_in   (alu_res_in),
    .st_val_in    (st_val_in),
    .dest_in      (dest_in),
    .wb_en_in     (wb_en_in),
    .mem_r_en_in  (mem_r_en_in),
    .mem_w_en_in  (mem_w_en_in),
    .mem_bus      (bus),
    .freeze_out   (freeze_out),
    .valid_out    (valid_out),
    .wb_en_out    (wb_en_out),
    .mem_r_en_out (mem_r_en_out),
    .pc_out       (pc_out),
    .alu_res_out  (alu_res_out),
    .mem_data_out (mem_data_out),
    .dest_out     (dest_out),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] st, input logic [3:0] d,
                       input logic wb, input logic r, input logic w);
    valid_in    = v;
    pc_in       = pc;
    alu_res_in  = alu;
    st_val_in   = st;
    dest_in     = d;
    wb_en_in    = wb;
    mem_r_en_in = r;
    mem_w_en_in = w;
  endtask

  task automatic idle_in;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'h0;
    idle_in();
    tick();
    tick();
    chk("rst_valid", valid_out, 0);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_err", err, 0);
    chk("rst_pc", pc_out, 0);
    rst = 1'b1;

    // ADD: single-cycle pass-through
    drive(1'b1, 32'h100, 32'h5, 32'h0, 4'd3, 1'b1, 1'b0, 1'b0);
    #1 chk("add_freeze", freeze_out, 0);
    tick();
    chk("add_valid", valid_out, 1);
    chk("add_wb", wb_en_out, 1);
    chk("add_alu", alu_res_out, 32'h5);
    chk("add_dest", dest_out, 3);
    chk("add_pc", pc_out, 32'h100);

    // STR to 1028, ack in cycle 3
    drive(1'b1, 32'h104, 32'd1028, 32'hDEADBEEF, 4'd0, 1'b0, 1'b0, 1'b1);
    #1 chk("str_freeze_c0", freeze_out, 1);
    chk("str_req_c0", bus.mem_req, 0);
    tick();
    chk("str_req_c1", bus.mem_req, 1);
    chk("str_we", bus.mem_we, 1);
    chk("str_addr", bus.mem_addr, 1);
    chk("str_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("str_freeze_c1", freeze_out, 1);
    chk("str_bubble_c1", valid_out, 0);
    tick();
    chk("str_freeze_c2", freeze_out, 1);
    tick();
    bus.mem_ack = 1'b1;
    #1 chk("str_freeze_c3", freeze_out, 0);
    tick();
    bus.mem_ack = 1'b0;
    idle_in();
    chk("str_valid", valid_out, 1);
    chk("str_wb", wb_en_out, 0);
    chk("str_pc", pc_out, 32'h104);
    chk("str_req_done", bus.mem_req, 0);

    // LDR from 1032, ack in cycle 1
    drive(1'b1, 32'h108, 32'd1032, 32'h0, 4'd7, 1'b1, 1'b1, 1'b0);
    tick();
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h1234;
    #1 chk("ldr_addr", bus.mem_addr, 2);
    chk("ldr_we", bus.mem_we, 0);
    chk("ldr_freeze_ack", freeze_out, 0);
    tick();
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'h0;
    idle_in();
    chk("ldr_data", mem_data_out, 32'h1234);
    chk("ldr_ren", mem_r_en_out, 1);
    chk("ldr_wb", wb_en_out, 1);
    chk("ldr_valid", valid_out, 1);
    chk("ldr_dest", dest_out, 7);

    // Misaligned LDR
    drive(1'b1, 32'h10C, 32'd1026, 32'h0, 4'd1, 1'b1, 1'b1, 1'b0);
    #1 chk("mis_freeze", freeze_out, 0);
    chk("mis_req", bus.mem_req, 0);
    tick();
    idle_in();
    chk("mis_err", err, 1);
    chk("mis_bubble", valid_out, 0);
    chk("mis_req_after", bus.mem_req, 0);
    chk("mis_data_hold", mem_data_out, 32'h1234);
    tick();
    chk("mis_err_once", err, 0);

    // Below base
    drive(1'b1, 32'h110, 32'd900, 32'h0, 4'd1, 1'b1, 1'b1, 1'b0);
    tick();
    idle_in();
    chk("low_err", err, 1);
    chk("low_req", bus.mem_req, 0);
    chk("low_bubble", valid_out, 0);
    tick();
    chk("low_err_once", err, 0);

    // One past the last word
    drive(1'b1, 32'h114, 32'd1280, 32'h0, 4'd1, 1'b1, 1'b1, 1'b0);
    tick();
    idle_in();
    chk("high_err", err, 1);
    chk("high_req", bus.mem_req, 0);

    // Last word is legal
    drive(1'b1, 32'h118, 32'd1276, 32'h0, 4'd2, 1'b1, 1'b1, 1'b0);
    #1 chk("last_freeze", freeze_out, 1);
    tick();
    chk("last_addr", bus.mem_addr, 63);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h77;
    tick();
    bus.mem_ack = 1'b0;
    idle_in();
    chk("last_data", mem_data_out, 32'h77);
    chk("last_err", err, 0);

    // Timeout: LDR with no ack
    drive(1'b1, 32'h11C, 32'd1040, 32'h0, 4'd5, 1'b1, 1'b1, 1'b0);
    req_cnt = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (bus.mem_req === 1'b1) req_cnt++;
    end
    chk("to_freeze_last", freeze_out, 0);
    tick();
    idle_in();
    chk("to_req_cycles", req_cnt, 16);
    chk("to_req_drop", bus.mem_req, 0);
    chk("to_err", err, 1);
    chk("to_bubble_v", valid_out, 0);
    chk("to_bubble_wb", wb_en_out, 0);
    #1 chk("to_freeze", freeze_out, 0);
    tick();
    chk("to_err_once", err, 0);

    // Flush during ACCESS: write still completes, result is a bubble
    drive(1'b1, 32'h120, 32'd1048, 32'h55, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    flush = 1'b1;
    #1 chk("fla_req", bus.mem_req, 1);
    tick();
    flush = 1'b0;
    bus.mem_ack = 1'b1;
    #1 chk("fla_addr", bus.mem_addr, 6);
    chk("fla_we", bus.mem_we, 1);
    tick();
    bus.mem_ack = 1'b0;
    idle_in();
    chk("fla_bubble", valid_out, 0);
    chk("fla_req_done", bus.mem_req, 0);

    // Flush in IDLE on a memory op: no request, no error
    drive(1'b1, 32'h124, 32'd1032, 32'h0, 4'd4, 1'b1, 1'b1, 1'b0);
    flush = 1'b1;
    #1 chk("fli_freeze", freeze_out, 0);
    tick();
    flush = 1'b0;
    idle_in();
    chk("fli_req", bus.mem_req, 0);
    chk("fli_err", err, 0);
    chk("fli_bubble", valid_out, 0);

    // Reset in the middle of an ACCESS
    drive(1'b1, 32'h128, 32'd1028, 32'h99, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    #1 chk("rmid_req", bus.mem_req, 0);
    chk("rmid_valid", valid_out, 0);
    chk("rmid_pc", pc_out, 0);
    chk("rmid_data", mem_data_out, 0);
    chk("rmid_dest", dest_out, 0);
    idle_in();
    tick();
    rst = 1'b1;
    drive(1'b1, 32'h12C, 32'd1036, 32'h0, 4'd9, 1'b1, 1'b1, 1'b0);
    #1 chk("rpost_freeze", freeze_out, 1);
    tick();
    chk("rpost_req", bus.mem_req, 1);
    chk("rpost_addr", bus.mem_addr, 3);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hCAFE;
    tick();
    bus.mem_ack = 1'b0;
    idle_in();
    chk("rpost_data", mem_data_out, 32'hCAFE);
    chk("rpost_dest", dest_out, 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
